// File: rtl/victim_pkg.sv
// Shared types and widths for the victim-cache swap controller.
package victim_pkg;

    localparam int PTAG_W   = 44;
    localparam int BLOCK_W  = 512;
    localparam int OFFSET_W = 12;
    localparam int VINDEX_W = 6;
    localparam int BYTE_W   = 8;
    localparam int VC_LAT   = 3;
    localparam int VC_WAYS  = 8;
    localparam int STAT_W   = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LK0,
        ST_LK1,
        ST_LK2,
        ST_LK3,
        ST_SW0,
        ST_SW1,
        ST_SW2,
        ST_SW3,
        ST_WB,
        ST_RESP
    } state_t;

    // Line-aligned page offset for a given vindex (byte offset zero).
    function automatic logic [OFFSET_W-1:0] line_offset(input logic [VINDEX_W-1:0] vindex);
        return {vindex, {(OFFSET_W-VINDEX_W){1'b0}}};
    endfunction

endpackage

// File: rtl/victim_swap_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16,
    parameter int MAX   = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/victim_swap_ctrl.sv
// L1-miss initiator for the 8-way victim cache: lookup, swap-in of the evicted line, writeback, response.
// Optional hit/miss statistics ports are built when VICTIM_SWAP_STATS_EN is defined.
module victim_swap_ctrl
    import victim_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OFFSET_W-1:0] req_page_offset,
    input  logic [PTAG_W-1:0]   req_ptag,
    input  logic                req_evict_valid,
    input  logic [VINDEX_W-1:0] req_evict_vindex,
    input  logic [PTAG_W-1:0]   req_evict_ptag,
    input  logic [BLOCK_W-1:0]  req_evict_block,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic [BYTE_W-1:0]   resp_byte,
    output logic [BLOCK_W-1:0]  resp_block,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [BLOCK_W-1:0]  wb_block,
    output logic [OFFSET_W-1:0] vc_page_offset,
    output logic [BLOCK_W-1:0]  vc_data_in,
    output logic                vc_write_en,
    output logic [PTAG_W-1:0]   vc_phys_tag_ret,
    output logic                vc_tlb_miss,
    input  logic [BYTE_W-1:0]   vc_byte_out,
    input  logic                vc_is_found,
    input  logic [BLOCK_W-1:0]  vc_block_out
`ifdef VICTIM_SWAP_STATS_EN
    ,
    output logic [STAT_W-1:0]   hit_count,
    output logic [STAT_W-1:0]   miss_count
`endif
);

    localparam int OCC_W = $clog2(VC_WAYS + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(VC_WAYS);

    state_t               state_reg;
    logic [PTAG_W-1:0]    ptag_reg;
    logic                 evict_valid_reg;
    logic [VINDEX_W-1:0]  evict_vindex_reg;
    logic [PTAG_W-1:0]    evict_ptag_reg;
    logic [BLOCK_W-1:0]   evict_block_reg;
    logic                 victim_valid_reg;
    logic [OCC_W-1:0]     occupancy;

    // Every install fills a way until the cache is full; after that each install displaces one.
    sat_counter #(
        .WIDTH (OCC_W),
        .MAX   (VC_WAYS)
    ) u_occupancy (
        .clk   (clk),
        .reset (reset),
        .inc   (state_reg == ST_SW3),
        .count (occupancy)
    );

`ifdef VICTIM_SWAP_STATS_EN
    sat_counter #(
        .WIDTH (STAT_W),
        .MAX   ((1 << STAT_W) - 1)
    ) u_hit_count (
        .clk   (clk),
        .reset (reset),
        .inc   ((state_reg == ST_LK3) && vc_is_found),
        .count (hit_count)
    );

    sat_counter #(
        .WIDTH (STAT_W),
        .MAX   ((1 << STAT_W) - 1)
    ) u_miss_count (
        .clk   (clk),
        .reset (reset),
        .inc   ((state_reg == ST_LK3) && !vc_is_found),
        .count (miss_count)
    );
`endif

    // Outputs are registered: each branch loads the drive for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            req_ready        <= 1'b0;
            ptag_reg         <= '0;
            evict_valid_reg  <= 1'b0;
            evict_vindex_reg <= '0;
            evict_ptag_reg   <= '0;
            evict_block_reg  <= '0;
            victim_valid_reg <= 1'b0;
            resp_valid       <= 1'b0;
            resp_hit         <= 1'b0;
            resp_byte        <= '0;
            resp_block       <= '0;
            wb_valid         <= 1'b0;
            wb_block         <= '0;
            vc_page_offset   <= '0;
            vc_data_in       <= '0;
            vc_write_en      <= 1'b0;
            vc_phys_tag_ret  <= '0;
            vc_tlb_miss      <= 1'b1;
        end else begin
            vc_page_offset  <= '0;
            vc_data_in      <= '0;
            vc_write_en     <= 1'b0;
            vc_phys_tag_ret <= '0;
            vc_tlb_miss     <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready        <= 1'b0;
                        ptag_reg         <= req_ptag;
                        evict_valid_reg  <= req_evict_valid;
                        evict_vindex_reg <= req_evict_vindex;
                        evict_ptag_reg   <= req_evict_ptag;
                        evict_block_reg  <= req_evict_block;
                        vc_page_offset   <= req_page_offset;
                        state_reg        <= ST_LK0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_LK0: begin
                    vc_phys_tag_ret <= ptag_reg;
                    vc_tlb_miss     <= 1'b0;
                    state_reg       <= ST_LK1;
                end
                ST_LK1: state_reg <= ST_LK2;
                ST_LK2: state_reg <= ST_LK3;
                ST_LK3: begin
                    resp_hit   <= vc_is_found;
                    resp_byte  <= vc_is_found ? vc_byte_out : '0;
                    resp_block <= vc_is_found ? vc_block_out : '0;
                    if (evict_valid_reg) begin
                        vc_write_en      <= 1'b1;
                        vc_page_offset   <= line_offset(evict_vindex_reg);
                        vc_data_in       <= evict_block_reg;
                        victim_valid_reg <= (occupancy == OCC_FULL);
                        state_reg        <= ST_SW0;
                    end else begin
                        resp_valid <= 1'b1;
                        state_reg  <= ST_RESP;
                    end
                end
                ST_SW0: begin
                    vc_phys_tag_ret <= evict_ptag_reg;
                    vc_tlb_miss     <= 1'b0;
                    state_reg       <= ST_SW1;
                end
                ST_SW1: state_reg <= ST_SW2;
                ST_SW2: state_reg <= ST_SW3;
                ST_SW3: begin
                    // Displaced line only carries real data once all ways were occupied.
                    if (victim_valid_reg) begin
                        wb_valid  <= 1'b1;
                        wb_block  <= vc_block_out;
                        state_reg <= ST_WB;
                    end else begin
                        resp_valid <= 1'b1;
                        state_reg  <= ST_RESP;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        wb_valid   <= 1'b0;
                        resp_valid <= 1'b1;
                        state_reg  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                    wb_valid   <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// Directed bench for victim_swap_ctrl with a cycle-stamped victim-cache output model.
module tb_victim_swap_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [11:0]  req_page_offset = '0;
    logic [43:0]  req_ptag = '0;
    logic         req_evict_valid = 1'b0;
    logic [5:0]   req_evict_vindex = '0;
    logic [43:0]  req_evict_ptag = '0;
    logic [511:0] req_evict_block = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic         resp_hit;
    logic [7:0]   resp_byte;
    logic [511:0] resp_block;
    logic         wb_valid;
    logic         wb_ready = 1'b1;
    logic [511:0] wb_block;
    logic [11:0]  vc_page_offset;
    logic [511:0] vc_data_in;
    logic         vc_write_en;
    logic [43:0]  vc_phys_tag_ret;
    logic         vc_tlb_miss;
    logic [7:0]   vc_byte_out;
    logic         vc_is_found;
    logic [511:0] vc_block_out;
`ifdef VICTIM_SWAP_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    logic [31:0]  cyc = '0;
    logic [511:0] base_block = '0;
    logic         vary = 1'b0;
    logic         found = 1'b0;
    logic [7:0]   model_byte = '0;
    int           we_count = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (vc_write_en === 1'b1) we_count <= we_count + 1;

    // Model output: when vary is set the block carries the cycle stamp so sample timing is visible.
    assign vc_block_out = vary ? (base_block ^ {16{cyc}}) : base_block;
    assign vc_byte_out  = model_byte;
    assign vc_is_found  = found;

    victim_swap_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_page_offset  (req_page_offset),
        .req_ptag         (req_ptag),
        .req_evict_valid  (req_evict_valid),
        .req_evict_vindex (req_evict_vindex),
        .req_evict_ptag   (req_evict_ptag),
        .req_evict_block  (req_evict_block),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_hit         (resp_hit),
        .resp_byte        (resp_byte),
        .resp_block       (resp_block),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_block         (wb_block),
        .vc_page_offset   (vc_page_offset),
        .vc_data_in       (vc_data_in),
        .vc_write_en      (vc_write_en),
        .vc_phys_tag_ret  (vc_phys_tag_ret),
        .vc_tlb_miss      (vc_tlb_miss),
        .vc_byte_out      (vc_byte_out),
        .vc_is_found      (vc_is_found),
        .vc_block_out     (vc_block_out)
`ifdef VICTIM_SWAP_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and walks it cycle by cycle until a valid output or stop_at.
    task automatic run_req(input logic [43:0] ptag, input logic [11:0] off, input logic ev,
                           input logic [5:0] evi, input logic [43:0] evp, input logic [511:0] evb,
                           input int stop_at, output int lat, output logic [31:0] hs);
        int g;
        @(negedge clk);
        req_valid = 1'b1;
        req_ptag = ptag;
        req_page_offset = off;
        req_evict_valid = ev;
        req_evict_vindex = evi;
        req_evict_ptag = evp;
        req_evict_block = evb;
        g = 0;
        while (req_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("req_ready_before_hs", req_ready, 1);
        hs = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_evict_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) begin
                chk("lk0_page_offset", vc_page_offset, off);
                chk("lk0_write_en", vc_write_en, 0);
            end
            if (k == 2) begin
                chk("lk1_phys_tag", vc_phys_tag_ret, ptag);
                chk("lk1_tlb_miss", vc_tlb_miss, 0);
            end
            if (ev && k == 5) begin
                chk("sw0_write_en", vc_write_en, 1);
                chk("sw0_page_offset", vc_page_offset, {evi, 6'b0});
                chk("sw0_data_in", vc_data_in, evb);
            end
            if (ev && k == 6) chk("sw1_phys_tag", vc_phys_tag_ret, evp);
            if (k == stop_at) begin
                lat = k;
                return;
            end
            if (resp_valid === 1'b1 || wb_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_resp(input string tag, input logic hit, input logic [7:0] byt,
                               input logic [511:0] blk);
        chk({tag, "_resp_valid"}, resp_valid, 1);
        chk({tag, "_resp_hit"}, resp_hit, hit);
        chk({tag, "_resp_byte"}, resp_byte, byt);
        chk({tag, "_resp_block"}, resp_block, blk);
        @(negedge clk);
        chk({tag, "_resp_done"}, resp_valid, 0);
        chk({tag, "_req_ready_again"}, req_ready, 1);
    endtask

    initial begin
        int lat;
        logic [31:0] hs;
        int we0;
        logic [511:0] hb;
        logic [511:0] vb;
        logic [511:0] held;
        logic ok;

        hb = {8{64'h0123_4567_89AB_CDEF}};
        hb[47:40] = 8'h3C;
        vb = {16{32'hA5A5_0F0F}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_vc_tlb_miss", vc_tlb_miss, 1);
        chk("rst_vc_write_en", vc_write_en, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);

        // Plain miss, no evict
        base_block = vb; found = 1'b0; model_byte = 8'h77; vary = 1'b0;
        we0 = we_count;
        run_req(44'hA, 12'h005, 1'b0, '0, '0, '0, 0, lat, hs);
        chk("miss_latency", lat, 5);
        chk("miss_no_write_pulse", we_count - we0, 0);
        finish_resp("miss", 1'b0, 8'h00, '0);

        // Hit
        base_block = hb; found = 1'b1; model_byte = 8'h3C;
        run_req(44'hB, 12'h045, 1'b0, '0, '0, '0, 0, lat, hs);
        chk("hit_latency", lat, 5);
        finish_resp("hit", 1'b1, 8'h3C, hb);

        // Nine misses with evict; the ninth displaces a valid victim
        base_block = vb; found = 1'b0; vary = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i == 9) wb_ready = 1'b0;
            run_req(44'h100 + 44'(i), 12'h080, 1'b1, 6'(i), 44'(i), {16{32'(i) * 32'h1111_0001}},
                    0, lat, hs);
            chk($sformatf("ev%0d_latency", i), lat, 9);
            if (i < 9) begin
                chk($sformatf("ev%0d_no_wb", i), wb_valid, 0);
                finish_resp($sformatf("ev%0d", i), 1'b0, 8'h00, '0);
            end else begin
                chk("ev9_wb_valid", wb_valid, 1);
                chk("ev9_wb_block", wb_block, vb ^ {16{hs + 32'd8}});
                held = wb_block;
                ok = 1'b1;
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    if (wb_valid !== 1'b1 || wb_block !== held || resp_valid !== 1'b0) ok = 1'b0;
                end
                chk("ev9_wb_stall_stable", ok, 1);
                wb_ready = 1'b1;
                @(negedge clk);
                chk("ev9_wb_released", wb_valid, 0);
                finish_resp("ev9", 1'b0, 8'h00, '0);
            end
        end
        vary = 1'b0;

        // Response backpressure
        base_block = hb; found = 1'b1; model_byte = 8'h5A; resp_ready = 1'b0;
        run_req(44'hC, 12'h3FF, 1'b0, '0, '0, '0, 0, lat, hs);
        chk("bp_latency", lat, 5);
        ok = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_byte !== 8'h5A ||
                resp_block !== hb || req_ready !== 1'b0) ok = 1'b0;
        end
        chk("bp_resp_stable", ok, 1);
        resp_ready = 1'b1;
        finish_resp("bp", 1'b1, 8'h5A, hb);

`ifdef VICTIM_SWAP_STATS_EN
        chk("stats_hit_count", hit_count, 2);
        chk("stats_miss_count", miss_count, 10);
`endif

        // Reset during SW1
        found = 1'b0;
        run_req(44'hD, 12'h010, 1'b1, 6'h2A, 44'hDD, {16{32'hDEAD_BEEF}}, 6, lat, hs);
        chk("rst_mid_reached_sw1", lat, 6);
        reset = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_resp_hit", resp_hit, 0);
        chk("mid_rst_resp_block", resp_block, 0);
        chk("mid_rst_wb_block", wb_block, 0);
        chk("mid_rst_vc_phys_tag", vc_phys_tag_ret, 0);
        chk("mid_rst_vc_tlb_miss", vc_tlb_miss, 1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_held_req_ready", req_ready, 0);
        chk("mid_rst_held_wb_valid", wb_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("after_rst_req_ready", req_ready, 1);
`ifdef VICTIM_SWAP_STATS_EN
        chk("after_rst_hit_count", hit_count, 0);
        chk("after_rst_miss_count", miss_count, 0);
`endif

        // Occupancy cleared: one evict after reset must not write back
        run_req(44'hE, 12'h020, 1'b1, 6'h01, 44'hEE, {16{32'h1234_5678}}, 0, lat, hs);
        chk("after_rst_ev_latency", lat, 9);
        chk("after_rst_ev_no_wb", wb_valid, 0);
        finish_resp("after_rst_ev", 1'b0, 8'h00, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/victim_swap_ctrl.md
# victim_swap_ctrl

Initiator-side controller for the 8-way victim cache: accepts one L1-miss request at a time and runs a lookup on the victim cache. It then installs the L1's evicted block via a victim-cache write and forwards any displaced valid victim block to the writeback path. Finally, it returns hit/miss, byte and block to the L1 miss handler. It sits between the L1 miss handler and the victim cache, and drives the victim cache's late-arriving physical tag and TLB-miss inputs itself.

## Interface
- VC_LAT, 3, cycles from victim-cache inputs presented to outputs valid
- VC_WAYS, 8, victim-cache entries; occupancy saturation point
- Clocking: one clock; reset is asynchronous and active-low. Ports are `clk` and `reset`.
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1 / 1  request handshake
- req_page_offset  in  12  [11:6] vindex, [5:0] byte offset
- req_ptag  in  44  physical tag of requested line
- req_evict_valid  in  1  L1 evicted a valid line with this miss
- req_evict_vindex  in  6  vindex of evicted line
- req_evict_ptag  in  44  ptag of evicted line
- req_evict_block  in  512  evicted line data
- resp_valid / resp_ready  out / in  1 / 1  response handshake
- resp_hit  out  1  line found in victim cache
- resp_byte  out  8  addressed byte (0x00 on miss)
- resp_block  out  512  hit line (0 on miss)
- wb_valid / wb_ready  out / in  1 / 1  writeback handshake
- wb_block  out  512  displaced victim line
- vc_page_offset, vc_data_in, vc_write_en  out  12, 512, 1  victim-cache stage-0 inputs
- vc_phys_tag_ret, vc_tlb_miss  out  44, 1  victim-cache stage-1 inputs
- vc_byte_out, vc_is_found, vc_block_out  in  8, 1, 512  victim-cache outputs
- hit_count, miss_count  out  16, 16  present only with VICTIM_SWAP_STATS_EN

## Operation
- States: IDLE, LK0..LK3, SW0..SW3, WB, RESP.
- IDLE: req_ready=1. On handshake, latch all req_* fields and go to LK0.
- LK0: vc_page_offset=req_page_offset, vc_write_en=0.
- LK1: vc_phys_tag_ret=req_ptag, vc_tlb_miss=0.
- LK2: wait.
- LK3: latch vc_is_found into hit. On hit, latch vc_byte_out and vc_block_out; on miss, latch zeros. Go to SW0 if evict latched, else RESP.
- SW0: vc_write_en=1, vc_page_offset={req_evict_vindex,6'b0}, vc_data_in=req_evict_block.
- SW1: vc_phys_tag_ret=req_evict_ptag, vc_tlb_miss=0.
- SW2: wait.
- SW3: latch vc_block_out as victim.
- Writeback decision: the displaced victim is valid only if occupancy == VC_WAYS, sampled at SW0 entry. SW3 goes to WB if the victim is valid, else RESP.
- Occupancy counter: 0..VC_WAYS, saturating. It increments at SW3 while below VC_WAYS.
- WB: wb_valid=1 and wb_block held until wb_ready, then go to RESP.
- RESP: resp_valid=1 and resp_* held until resp_ready, then go to IDLE.
- Idle victim-cache drive, i.e. every cycle not listed above: vc_write_en=0, vc_tlb_miss=1, vc_page_offset/vc_data_in/vc_phys_tag_ret=0.
- Upstream guarantees the evicted line is never resident in the victim cache. The controller performs no duplicate check.

## Timing
- Reset values: req_ready=0 during reset, 1 in the first cycle after release. resp_valid=0, resp_hit=0, resp_byte=0, resp_block=0, wb_valid=0, wb_block=0, vc_* at idle drive, occupancy=0, counters=0.
- Handshake rule: a transfer occurs on a clock edge with valid&&ready both high. Valid never drops without its ready.
- Latency without evict, request handshake at cycle 0: LK0 in cycle 1, sample in cycle 4, resp_valid in cycle 5.
- Latency with evict: SW0 in cycle 5, SW3 in cycle 8, WB or RESP in cycle 9. RESP follows the cycle after the wb handshake.
- Only one request is in flight. A new req is accepted no earlier than the cycle after the resp handshake.
- Backpressure: resp_ready or wb_ready low stalls the FSM indefinitely with outputs stable.
- Reset asserted mid-operation: the FSM is forced to IDLE immediately, the in-flight request is dropped, and all outputs take their reset values.

## Configuration
- VICTIM_SWAP_STATS_EN defined: hit_count and miss_count are present. Each is 16-bit, saturating at 0xFFFF, and increments at LK3 on hit or miss respectively. Both clear on reset.
- VICTIM_SWAP_STATS_EN not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package victim_pkg holds:
  - state enum
  - widths PTAG_W=44, BLOCK_W=512, OFFSET_W=12, VINDEX_W=6
  - VC_LAT default
- One sub-module, sat_counter (parameter width and max; inc and reset). It is used for occupancy and, when enabled, the stats counters.

## Test plan
- Reset then lookup of ptag 0xA, offset 0x005 with vc_is_found=0 and no evict -> resp_valid in cycle 5, resp_hit=0, resp_byte=0x00, resp_block=0, no vc_write_en pulse.
- Lookup with the model returning found=1, block byte 5=0x3C -> resp_hit=1, resp_byte=0x3C, resp_block equals the model block.
- Nine misses with evict (ptags 1..9): first eight produce no wb_valid. The ninth raises wb_valid with wb_block equal to the model's vc_block_out at SW3.
- wb_ready held low 10 cycles on the ninth request -> wb_valid/wb_block stable, no resp_valid until one cycle after the wb handshake.
- resp_ready low 5 cycles -> resp_* stable and req_ready=0 throughout.
- reset pulled low at SW1 -> req_ready=0 and all outputs at reset values while low. After release: req_ready=1, occupancy 0, the next request completes normally. With stats enabled, counters read 0.
